// File: rtl/bp_grad_update.sv
// Backprop weight-update stage: accumulates delta*act over a batch, then issues
// a saturated w_cur - lr*grad update with a one-cycle capture enable.
module bp_grad_update #(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned FRAC     = 16,
    parameter int unsigned NSAMPLE  = 16,
    parameter int unsigned LR_SHIFT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DWIDTH-1:0] delta,
    input  logic [DWIDTH-1:0] act,
    input  logic [DWIDTH-1:0] w_cur,
    output logic [DWIDTH-1:0] w_next,
    output logic              w_en,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PW   = 2 * DWIDTH;
    localparam int unsigned ACCW = 2 * DWIDTH - FRAC + 8;
    localparam int unsigned DFW  = ACCW + 1;
    localparam int unsigned HW   = DFW - (DWIDTH - 1);
    localparam int unsigned CW   = $clog2(NSAMPLE + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC    = 2'd1,
        UPDATE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                   state;
    logic signed [ACCW-1:0]   acc;
    logic        [CW-1:0]     cnt;

    logic signed [PW-1:0]     prod;
    logic signed [ACCW-1:0]   prod_sh;
    logic signed [DFW-1:0]    diff;
    logic        [HW-1:0]     diff_hi;
    logic        [DWIDTH-1:0] w_sat;

    // Fixed-point product rescaled by FRAC (floor), then update value saturated to DWIDTH.
    always_comb begin
        prod    = $signed(delta) * $signed(act);
        prod_sh = ACCW'(prod >>> FRAC);
        diff    = DFW'($signed(w_cur)) - DFW'(acc >>> LR_SHIFT);
        diff_hi = diff[DFW-1:DWIDTH-1];
        w_sat   = diff[DWIDTH-1:0];
        if (!((diff_hi == {HW{1'b0}}) || (diff_hi == {HW{1'b1}}))) begin
            w_sat = diff[DFW-1] ? {1'b1, {(DWIDTH-1){1'b0}}}
                                : {1'b0, {(DWIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            w_next <= '0;
            w_en   <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            w_en <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACC;
                        busy  <= 1'b1;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        acc <= acc + prod_sh;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(NSAMPLE - 1)) begin
                            state <= UPDATE;
                        end
                    end
                end
                UPDATE: begin
                    w_next <= w_sat;
                    w_en   <= 1'b1;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/bp_grad_update.md
Name: bp_grad_update

Overview:
Backprop weight-update stage that sits directly upstream of the weight-holding enable register bank.
- Accumulates delta*activation products over a batch of NSAMPLE samples in signed fixed point.
- Computes w_next = sat(w_cur - (grad_sum >>> LR_SHIFT)).
- Issues a single-cycle w_en pulse so the downstream register captures w_next.
- One instance per weight; w_cur is looped back from that register's output.

Parameters:
DWIDTH, 32, data width of delta/act/weights, signed two's complement
FRAC, 16, fractional bits of fixed-point format (1.0 = 2^FRAC)
NSAMPLE, 16, samples per batch, legal range 1..256
LR_SHIFT, 4, learning rate as arithmetic right shift (lr = 2^-LR_SHIFT)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
start  in  1  begin new batch; honoured only in IDLE
in_valid  in  1  delta/act sample valid this cycle
delta  in  DWIDTH  signed error term
act  in  DWIDTH  signed activation
w_cur  in  DWIDTH  signed current weight, fed back from downstream register output
w_next  out  DWIDTH  signed updated weight, registered
w_en  out  1  one-cycle enable to downstream register
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse, coincident with w_en

Behaviour:
Reset and clocking:
- Single clock clk. Reset rst is synchronous and active-low.
- On a clk edge with rst=0: state=IDLE, acc=0, cnt=0, w_next=0, w_en=0, done=0, busy=0.
- Reset overrides every other input and aborts any batch mid-operation. No w_en pulse follows an aborted batch.

FSM states: IDLE, ACC, UPDATE, DONE.
- IDLE: on start=1, clear acc and cnt, go to ACC. in_valid is ignored in IDLE.
- ACC: on each edge with in_valid=1:
  - form the 2*DWIDTH signed product delta*act;
  - arithmetic-shift it right by FRAC (truncation toward -inf);
  - sign-extend it and add to acc;
  - increment cnt.
  - When the accepted sample is number NSAMPLE (cnt==NSAMPLE-1 before increment), go to UPDATE.
  - Cycles with in_valid=0 leave acc and cnt unchanged. Gaps are unlimited.
- UPDATE: single cycle.
  - Sample w_cur.
  - Compute diff = w_cur - (acc >>> LR_SHIFT) at full accumulator width.
  - Saturate diff to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1] and register it into w_next.
  - Go to DONE.
- DONE: single cycle with w_en=1 and done=1. Next state is IDLE.

Arithmetic:
- Accumulator width ACCW = 2*DWIDTH-FRAC+8. With NSAMPLE<=256 the accumulator cannot overflow; no wrap-around is permitted.

Latency:
- w_en is high in the 2nd cycle after the edge that accepts the last sample.
- Total batch time is NSAMPLE valid cycles + 2 cycles.

Boundary conditions:
- start while busy=1: ignored, with no effect on acc, cnt or state.
- start and in_valid both high in IDLE: only start acts. That sample is not accumulated.
- NSAMPLE=1: the first valid sample goes straight to UPDATE.
- w_next holds its value between batches; it changes only in UPDATE or on reset.
- w_en and done are never high for more than one consecutive cycle.
- back-to-back batches: start may be asserted the cycle after DONE (state is IDLE).

Test Plan:
(Override NSAMPLE=4, LR_SHIFT=2, FRAC=16, DWIDTH=32.)
- Basic update: start; 4 samples delta=65536 (1.0), act=65536; w_cur=131072 -> acc=262144, w_next=65536, w_en=1 exactly one cycle, 2 cycles after the 4th sample, done coincident.
- Negative gradient: 4 samples delta=-32768 (-0.5), act=65536; w_cur=0 -> acc=-131072, w_next=32768.
- Positive saturation: 4 samples delta=-65536, act=65536; w_cur=0x7FFFFF00 -> w_next=0x7FFFFFFF. Mirror case: delta=+65536, w_cur=0x80000100 -> w_next=0x80000000.
- Valid gaps and truncation:
  - Test 1 with in_valid=0 inserted between every sample -> identical w_next=65536, w_en timing relative to the 4th valid sample unchanged.
  - delta=-1, act=1 -> each product >>>16 gives -1 (toward -inf), not 0.
- Reset mid-batch: rst=0 for one edge after 2 samples -> all outputs 0 next cycle, no w_en ever. A fresh start plus Test 1 stimulus then gives w_next=65536.
- Start during busy: assert start in ACC after sample 2 and again in UPDATE -> ignored. Result matches Test 1 and exactly one w_en pulse occurs.
